// File: rtl/serial_frame_deframer.sv
// Serial deframer: hunts a zeros/ones preamble, then unpacks start/data/stop frames onto a parallel word and channel strobes.
// Latency: result pulses one clk after the stop bit is sampled. No backpressure; bits advance only on bit_en.
// Optional parity bit between data and stop when DATA_CONVERTER_PARITY_EN is defined.
module serial_frame_deframer #(
  parameter int DATA_W    = 8,
  parameter int PRE_ZEROS = 10,
  parameter int PRE_ONES  = 9,
  parameter int NUM_CH    = 3,
  parameter int MODE_W    = 2,
  parameter int ERR_MAX   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              din,
  input  logic [MODE_W-1:0] mode,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [NUM_CH-1:0] ch_valid,
  output logic              lock,
  output logic              frame_err,
  output logic              par_err
);

  localparam int ZW = $clog2(PRE_ZEROS + 1);
  localparam int OW = $clog2(PRE_ONES + 1);
  localparam int EW = $clog2(ERR_MAX + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [ZW-1:0] ZMAX = ZW'(PRE_ZEROS);
  localparam logic [OW-1:0] OMAX = OW'(PRE_ONES);
  localparam logic [EW-1:0] EMAX = EW'(ERR_MAX);
  localparam logic [BW-1:0] BMAX = BW'(DATA_W - 1);

  if (ERR_MAX < 1 || DATA_W < 2) begin : g_param_check
    $error("serial_frame_deframer: ERR_MAX must be >= 1 and DATA_W >= 2");
  end

  typedef enum logic [2:0] {
    HUNT_Z,
    HUNT_O,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state, state_n;
  logic [ZW-1:0]       zcnt, zcnt_n;
  logic [OW-1:0]       ocnt, ocnt_n;
  logic [EW-1:0]       errcnt, errcnt_n, err_inc;
  logic [BW-1:0]       bitcnt, bitcnt_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic [DATA_W-1:0]   dout_n;
  logic                valid_n;
  logic [NUM_CH-1:0]   ch_valid_n;
  logic                lock_n;
  logic                frame_err_n;
  logic                par_err_n;
  logic                bad;

`ifdef DATA_CONVERTER_PARITY_EN
  logic                par_bad, par_bad_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT_Z;
      zcnt      <= '0;
      ocnt      <= '0;
      errcnt    <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      ch_valid  <= '0;
      lock      <= 1'b0;
      frame_err <= 1'b0;
`ifdef DATA_CONVERTER_PARITY_EN
      par_bad   <= 1'b0;
      par_err   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      zcnt      <= zcnt_n;
      ocnt      <= ocnt_n;
      errcnt    <= errcnt_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      dout      <= dout_n;
      valid     <= valid_n;
      ch_valid  <= ch_valid_n;
      lock      <= lock_n;
      frame_err <= frame_err_n;
`ifdef DATA_CONVERTER_PARITY_EN
      par_bad   <= par_bad_n;
      par_err   <= par_err_n;
`endif
    end
  end

`ifndef DATA_CONVERTER_PARITY_EN
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    zcnt_n      = zcnt;
    ocnt_n      = ocnt;
    errcnt_n    = errcnt;
    bitcnt_n    = bitcnt;
    shreg_n     = shreg;
    dout_n      = dout;
    lock_n      = lock;
    valid_n     = 1'b0;
    ch_valid_n  = '0;
    frame_err_n = 1'b0;
    par_err_n   = 1'b0;
    bad         = 1'b0;
    err_inc     = errcnt + EW'(1);
`ifdef DATA_CONVERTER_PARITY_EN
    par_bad_n   = par_bad;
`endif

    if (bit_en) begin
      unique case (state)
        HUNT_Z: begin
          if (!din) begin
            if (zcnt != ZMAX) zcnt_n = zcnt + ZW'(1);
          end else if (zcnt == ZMAX) begin
            state_n = HUNT_O;
            ocnt_n  = OW'(1);
            zcnt_n  = '0;
          end else begin
            zcnt_n = '0;
          end
        end

        // Once the full run of ones is seen, the next '1' is the first start bit.
        HUNT_O: begin
          if (din && ocnt == OMAX) begin
            state_n  = DATA;
            lock_n   = 1'b1;
            errcnt_n = '0;
            bitcnt_n = BMAX;
          end else if (din) begin
            ocnt_n = ocnt + OW'(1);
          end else begin
            state_n = HUNT_Z;
            zcnt_n  = ZW'(1);
          end
        end

        START: begin
          if (din) begin
            state_n  = DATA;
            bitcnt_n = BMAX;
          end else begin
            frame_err_n = 1'b1;
            bad         = 1'b1;
          end
        end

        DATA: begin
          shreg_n = {shreg[DATA_W-2:0], din};
          if (bitcnt == '0) begin
`ifdef DATA_CONVERTER_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bitcnt_n = bitcnt - BW'(1);
          end
        end

`ifdef DATA_CONVERTER_PARITY_EN
        // Even parity: data bits plus parity bit must XOR to zero.
        PARITY: begin
          par_bad_n = ^{shreg, din};
          state_n   = STOP;
        end
`endif

        STOP: begin
          state_n = START;
          if (din) begin
            frame_err_n = 1'b1;
            bad         = 1'b1;
`ifdef DATA_CONVERTER_PARITY_EN
          end else if (par_bad) begin
            par_err_n = 1'b1;
            bad       = 1'b1;
`endif
          end else begin
            dout_n   = shreg;
            valid_n  = 1'b1;
            errcnt_n = '0;
            for (int i = 0; i < NUM_CH; i++) begin
              ch_valid_n[i] = (mode == MODE_W'(i));
            end
          end
        end

        default: begin
          state_n = HUNT_Z;
          zcnt_n  = '0;
          lock_n  = 1'b0;
        end
      endcase

      // The offending bit itself counts as the first zero of a new hunt.
      if (bad) begin
        if (err_inc == EMAX) begin
          state_n  = HUNT_Z;
          lock_n   = 1'b0;
          errcnt_n = '0;
          zcnt_n   = din ? ZW'(0) : ZW'(1);
        end else begin
          errcnt_n = err_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_deframer.sv
// Directed bench for serial_frame_deframer: vector table of locked frames plus hand-written preamble, error and reset sequences.
module tb_serial_frame_deframer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_en = 1'b0;
  logic       din = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] dout;
  logic       valid;
  logic [2:0] ch_valid;
  logic       lock;
  logic       frame_err;
  logic       par_err;

  serial_frame_deframer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bit_en),
    .din       (din),
    .mode      (mode),
    .dout      (dout),
    .valid     (valid),
    .ch_valid  (ch_valid),
    .lock      (lock),
    .frame_err (frame_err),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  int n_ferr = 0;

  logic       s_valid, s_ferr, s_perr, s_lock, start_lock;
  logic [2:0] s_ch;
  logic [7:0] s_dout;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] data;
    logic       stop;
    logic       e_valid;
    logic [2:0] e_ch;
    logic       e_ferr;
    logic [7:0] e_dout;
    logic       e_lock;
  } vec_t;

  vec_t vt [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bit every third clk; outputs captured 1 time unit after the sampling edge.
  task automatic send_bit(input logic b);
    repeat (2) @(negedge clk);
    @(negedge clk);
    din    = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    s_valid = valid;
    s_ch    = ch_valid;
    s_ferr  = frame_err;
    s_perr  = par_err;
    s_dout  = dout;
    s_lock  = lock;
    if (valid) n_valid++;
    if (frame_err) n_ferr++;
  endtask

  task automatic send_run(input logic b, input int n);
    for (int k = 0; k < n; k++) send_bit(b);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    send_bit(1'b1);
    start_lock = s_lock;
    for (int k = 7; k >= 0; k--) send_bit(d[k]);
`ifdef DATA_CONVERTER_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) send_bit(1'b1);
`endif
    send_bit(stop);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    int f0;
    //          mode  data   stop  valid ch      ferr  dout   lock
    vt[0]  = '{2'd0, 8'h00, 1'b0, 1'b1, 3'b001, 1'b0, 8'h00, 1'b1};
    vt[1]  = '{2'd0, 8'h01, 1'b0, 1'b1, 3'b001, 1'b0, 8'h01, 1'b1};
    vt[2]  = '{2'd0, 8'h02, 1'b0, 1'b1, 3'b001, 1'b0, 8'h02, 1'b1};
    vt[3]  = '{2'd0, 8'h03, 1'b0, 1'b1, 3'b001, 1'b0, 8'h03, 1'b1};
    vt[4]  = '{2'd0, 8'h04, 1'b0, 1'b1, 3'b001, 1'b0, 8'h04, 1'b1};
    vt[5]  = '{2'd0, 8'h05, 1'b0, 1'b1, 3'b001, 1'b0, 8'h05, 1'b1};
    vt[6]  = '{2'd1, 8'h5A, 1'b0, 1'b1, 3'b010, 1'b0, 8'h5A, 1'b1};
    vt[7]  = '{2'd2, 8'hC3, 1'b0, 1'b1, 3'b100, 1'b0, 8'hC3, 1'b1};
    vt[8]  = '{2'd3, 8'h81, 1'b0, 1'b1, 3'b000, 1'b0, 8'h81, 1'b1};
    vt[9]  = '{2'd0, 8'h77, 1'b1, 1'b0, 3'b000, 1'b1, 8'h81, 1'b1};
    vt[10] = '{2'd0, 8'h66, 1'b1, 1'b0, 3'b000, 1'b1, 8'h81, 1'b1};
    vt[11] = '{2'd0, 8'h11, 1'b0, 1'b1, 3'b001, 1'b0, 8'h11, 1'b1};
    vt[12] = '{2'd0, 8'h22, 1'b1, 1'b0, 3'b000, 1'b1, 8'h11, 1'b1};
    vt[13] = '{2'd0, 8'h33, 1'b1, 1'b0, 3'b000, 1'b1, 8'h11, 1'b1};
    vt[14] = '{2'd0, 8'h44, 1'b1, 1'b0, 3'b000, 1'b1, 8'h11, 1'b0};

    // Reset state
    #1;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_lock", 32'(lock), 32'h0);
    check("rst_ch", 32'(ch_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Minimum preamble; lock must not rise before the start bit
    send_run(1'b0, 10);
    send_run(1'b1, 9);
    check("pre_lock_before_start", 32'(s_lock), 32'h0);

    for (int i = 0; i < 15; i++) begin
      mode = vt[i].mode;
      send_frame(vt[i].data, vt[i].stop, 1'b0);
      if (i == 0) check("lock_at_first_start", 32'(start_lock), 32'h1);
      check($sformatf("v%0d_valid", i), 32'(s_valid), 32'(vt[i].e_valid));
      check($sformatf("v%0d_ch", i), 32'(s_ch), 32'(vt[i].e_ch));
      check($sformatf("v%0d_ferr", i), 32'(s_ferr), 32'(vt[i].e_ferr));
      check($sformatf("v%0d_dout", i), 32'(s_dout), 32'(vt[i].e_dout));
      check($sformatf("v%0d_lock", i), 32'(s_lock), 32'(vt[i].e_lock));
    end
    mode = 2'd0;

    // Nine zeros are one short of a preamble
    v0 = n_valid;
    send_run(1'b0, 9);
    send_run(1'b1, 9);
    send_frame(8'hA5, 1'b0, 1'b0);
    check("short_pre_no_valid", 32'(n_valid - v0), 32'h0);
    check("short_pre_no_lock", 32'(s_lock), 32'h0);
    send_run(1'b0, 12);
    send_run(1'b1, 9);
    send_frame(8'hA5, 1'b0, 1'b0);
    check("long_pre_valid", 32'(s_valid), 32'h1);
    check("long_pre_dout", 32'(s_dout), 32'hA5);
    check("long_pre_lock", 32'(s_lock), 32'h1);

    // Missing start bit while locked
    send_bit(1'b0);
    check("start_err_ferr", 32'(s_ferr), 32'h1);
    check("start_err_lock", 32'(s_lock), 32'h1);

    // Asynchronous reset in the middle of 0x3C data bits
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", 32'(dout), 32'h0);
    check("midrst_lock", 32'(lock), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_ch", 32'(ch_valid), 32'h0);
    check("midrst_ferr", 32'(frame_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid;
    send_frame(8'h3C, 1'b0, 1'b0);
    check("post_rst_no_valid", 32'(n_valid - v0), 32'h0);
    check("post_rst_no_lock", 32'(s_lock), 32'h0);

    // A zero after partial ones restarts the zero count at one
    send_run(1'b0, 10);
    send_run(1'b1, 8);
    send_bit(1'b0);
    send_run(1'b0, 9);
    send_run(1'b1, 9);
    send_frame(8'h3C, 1'b0, 1'b0);
    check("relock_valid", 32'(s_valid), 32'h1);
    check("relock_dout", 32'(s_dout), 32'h3C);

    // Three missing start bits drop lock; the last zero seeds the next hunt
    f0 = n_ferr;
    send_bit(1'b0);
    check("serr1_lock", 32'(s_lock), 32'h1);
    send_bit(1'b0);
    check("serr2_lock", 32'(s_lock), 32'h1);
    send_bit(1'b0);
    check("serr3_ferr", 32'(s_ferr), 32'h1);
    check("serr3_lock", 32'(s_lock), 32'h0);
    check("serr_count", 32'(n_ferr - f0), 32'h3);
    check("serr_dout_held", 32'(dout), 32'h3C);
    send_run(1'b0, 9);
    send_run(1'b1, 9);
    send_frame(8'h96, 1'b0, 1'b0);
    check("seed_relock_valid", 32'(s_valid), 32'h1);
    check("seed_relock_dout", 32'(s_dout), 32'h96);

`ifdef DATA_CONVERTER_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b0);
    check("par_good_valid", 32'(s_valid), 32'h1);
    check("par_good_perr", 32'(s_perr), 32'h0);
    check("par_good_dout", 32'(s_dout), 32'h07);
    send_frame(8'h07, 1'b0, 1'b1);
    check("par_bad_valid", 32'(s_valid), 32'h0);
    check("par_bad_perr", 32'(s_perr), 32'h1);
    check("par_bad_dout", 32'(s_dout), 32'h07);
`else
    send_frame(8'h07, 1'b0, 1'b0);
    check("nopar_valid", 32'(s_valid), 32'h1);
    check("nopar_perr", 32'(s_perr), 32'h0);
    check("nopar_dout", 32'(s_dout), 32'h07);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
